// File: rtl/stack_status_ctrl.sv
// rtl/stack_status_ctrl.sv - stack pointer, RAM strobes, status flags and error tracking
//
// Ports:
//   clk, rst_edge            clock (rising edge) and async active-high reset
//   push_req/pop_req/peek_req request levels, each acts on its rising edge
//   clr_err                  synchronous clear of error, err_code, err_count
//   afull_lvl, aempty_lvl    almost-full / almost-empty thresholds
//   sp                       registered stack pointer (number of valid entries)
//   mem_we, mem_re, mem_addr combinational stack RAM strobes and address
//   stack_full/empty/threshold/afull/aempty  status flags from sp
//   error, err_code, err_count  registered error flag, first cause, saturating count
module stack_status_ctrl #(
    parameter int STACK_DEPTH = 16,
    parameter bit STICKY_ERR  = 1'b0,
    parameter int ERR_CNT_W   = 8,
    localparam int PTR_W      = $clog2(STACK_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_edge,
    input  logic                 push_req,
    input  logic                 pop_req,
    input  logic                 peek_req,
    input  logic                 clr_err,
    input  logic [PTR_W-1:0]     afull_lvl,
    input  logic [PTR_W-1:0]     aempty_lvl,
    output logic [PTR_W-1:0]     sp,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [PTR_W-2:0]     mem_addr,
    output logic                 stack_full,
    output logic                 stack_empty,
    output logic                 stack_threshold,
    output logic                 stack_afull,
    output logic                 stack_aempty,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [PTR_W-1:0]     DEPTH_V = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]     HALF_V  = PTR_W'(STACK_DEPTH / 2);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_UNDER = 2'b10;
    localparam logic [1:0] CODE_PEEK  = 2'b11;

    typedef enum logic {ST_OK, ST_ERR} err_state_t;

    err_state_t       state;
    logic             push_d, pop_d, peek_d;
    logic             e_push, e_pop, e_peek;
    logic [PTR_W-2:0] sp_m1;
    logic [PTR_W-1:0] sp_next;
    logic             err_ev;
    logic [1:0]       err_cause;
    logic             op_ok;
    logic [ERR_CNT_W-1:0] cnt_inc;

    assign e_push = push_req & ~push_d;
    assign e_pop  = pop_req  & ~pop_d;
    assign e_peek = peek_req & ~peek_d;

    // Address of the current top entry; only used when the stack is not empty.
    assign sp_m1 = sp[PTR_W-2:0] - (PTR_W-1)'(1);

    assign stack_full      = (sp == DEPTH_V);
    assign stack_empty     = (sp == '0);
    assign stack_threshold = (sp >= HALF_V);
    assign stack_afull     = (sp >= afull_lvl);
    assign stack_aempty    = (sp <= aempty_lvl);

    assign cnt_inc = (err_count == CNT_MAX) ? err_count : err_count + ERR_CNT_W'(1);

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        sp_next   = sp;
        err_ev    = 1'b0;
        err_cause = CODE_NONE;
        op_ok     = 1'b0;
        if (e_push && e_pop) begin
            op_ok  = 1'b1;
            mem_we = 1'b1;
            if (stack_empty) begin
                // Nothing to pop: behave as a plain push into slot 0.
                mem_addr = sp[PTR_W-2:0];
                sp_next  = sp + PTR_W'(1);
            end else begin
                // Replace top in place: read old value and overwrite it.
                mem_re   = 1'b1;
                mem_addr = sp_m1;
            end
        end else if (e_push) begin
            if (stack_full) begin
                err_ev    = 1'b1;
                err_cause = CODE_OVER;
            end else begin
                op_ok    = 1'b1;
                mem_we   = 1'b1;
                mem_addr = sp[PTR_W-2:0];
                sp_next  = sp + PTR_W'(1);
            end
        end else if (e_pop) begin
            if (stack_empty) begin
                err_ev    = 1'b1;
                err_cause = CODE_UNDER;
            end else begin
                op_ok    = 1'b1;
                mem_re   = 1'b1;
                mem_addr = sp_m1;
                sp_next  = sp - PTR_W'(1);
            end
        end else if (e_peek) begin
            if (stack_empty) begin
                err_ev    = 1'b1;
                err_cause = CODE_PEEK;
            end else begin
                op_ok    = 1'b1;
                mem_re   = 1'b1;
                mem_addr = sp_m1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            sp     <= '0;
            push_d <= 1'b0;
            pop_d  <= 1'b0;
            peek_d <= 1'b0;
        end else begin
            sp     <= sp_next;
            push_d <= push_req;
            pop_d  <= pop_req;
            peek_d <= peek_req;
        end
    end

    // Error FSM. An error event outranks clr_err so a coincident clear
    // restarts the count at one with the new cause latched.
    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            state     <= ST_OK;
            error     <= 1'b0;
            err_code  <= CODE_NONE;
            err_count <= '0;
        end else if (err_ev) begin
            state <= ST_ERR;
            error <= 1'b1;
            if (clr_err) begin
                err_code  <= err_cause;
                err_count <= ERR_CNT_W'(1);
            end else begin
                if (state == ST_OK) begin
                    err_code <= err_cause;
                end
                err_count <= cnt_inc;
            end
        end else if (clr_err) begin
            state     <= ST_OK;
            error     <= 1'b0;
            err_code  <= CODE_NONE;
            err_count <= '0;
        end else if (!STICKY_ERR && op_ok && state == ST_ERR) begin
            state    <= ST_OK;
            error    <= 1'b0;
            err_code <= CODE_NONE;
        end
    end

endmodule

// File: tb/tb_stack_status_ctrl.sv
// tb/tb_stack_status_ctrl.sv - scoreboard bench for stack_status_ctrl (non-sticky and sticky instances)
module tb_stack_status_ctrl;

    localparam int D = 4;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst_edge = 1'b1;
    logic push_req = 1'b0, pop_req = 1'b0, peek_req = 1'b0, clr_err = 1'b0;
    logic [PW-1:0] afull_lvl = 3'd3;
    logic [PW-1:0] aempty_lvl = 3'd1;

    logic [PW-1:0] sp0, sp1;
    logic we0, re0, we1, re1;
    logic [PW-2:0] addr0, addr1;
    logic full0, empty0, thr0, afull0, aempty0;
    logic full1, empty1, thr1, afull1, aempty1;
    logic err0, err1;
    logic [1:0] code0, code1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stack_status_ctrl #(.STACK_DEPTH(D), .STICKY_ERR(1'b0), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .rst_edge(rst_edge), .push_req(push_req), .pop_req(pop_req),
        .peek_req(peek_req), .clr_err(clr_err), .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl),
        .sp(sp0), .mem_we(we0), .mem_re(re0), .mem_addr(addr0),
        .stack_full(full0), .stack_empty(empty0), .stack_threshold(thr0),
        .stack_afull(afull0), .stack_aempty(aempty0),
        .error(err0), .err_code(code0), .err_count(cnt0)
    );

    stack_status_ctrl #(.STACK_DEPTH(D), .STICKY_ERR(1'b1), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .rst_edge(rst_edge), .push_req(push_req), .pop_req(pop_req),
        .peek_req(peek_req), .clr_err(clr_err), .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl),
        .sp(sp1), .mem_we(we1), .mem_re(re1), .mem_addr(addr1),
        .stack_full(full1), .stack_empty(empty1), .stack_threshold(thr1),
        .stack_afull(afull1), .stack_aempty(aempty1),
        .error(err1), .err_code(code1), .err_count(cnt1)
    );

    typedef struct {
        int we, re, addr, sp;
        int full, empty, thr, afull, aempty;
        int err[2];
        int code[2];
        int cnt[2];
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int m_sp;
    int m_pd, m_od, m_kd;
    int m_err[2], m_code[2], m_cnt[2];
    int m_sticky[2] = '{0, 1};
    int m_cmax[2]   = '{255, 3};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sp = 0;
        m_pd = 0; m_od = 0; m_kd = 0;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0; m_code[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Drive one cycle of inputs and push the expected outcome.
    task automatic drive(input int p, input int o, input int k, input int c);
        exp_t e;
        int ep, eo, ek, ok, cause, nsp;
        @(negedge clk);
        push_req = p[0]; pop_req = o[0]; peek_req = k[0]; clr_err = c[0];
        ep = p & ~m_pd; eo = o & ~m_od; ek = k & ~m_kd;
        m_pd = p; m_od = o; m_kd = k;
        e.we = 0; e.re = 0; e.addr = 0;
        ok = 0; cause = 0; nsp = m_sp;
        if (ep && eo) begin
            ok = 1; e.we = 1;
            if (m_sp == 0) nsp = 1;
            else begin e.re = 1; e.addr = m_sp - 1; end
        end else if (ep) begin
            if (m_sp == D) cause = 1;
            else begin ok = 1; e.we = 1; e.addr = m_sp; nsp = m_sp + 1; end
        end else if (eo) begin
            if (m_sp == 0) cause = 2;
            else begin ok = 1; e.re = 1; e.addr = m_sp - 1; nsp = m_sp - 1; end
        end else if (ek) begin
            if (m_sp == 0) cause = 3;
            else begin ok = 1; e.re = 1; e.addr = m_sp - 1; end
        end
        m_sp = nsp;
        for (int i = 0; i < 2; i++) begin
            if (cause != 0) begin
                if (c) begin
                    m_code[i] = cause; m_cnt[i] = 1;
                end else begin
                    if (!m_err[i]) m_code[i] = cause;
                    if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                end
                m_err[i] = 1;
            end else if (c) begin
                m_err[i] = 0; m_code[i] = 0; m_cnt[i] = 0;
            end else if (ok && !m_sticky[i] && m_err[i]) begin
                m_err[i] = 0; m_code[i] = 0;
            end
            e.err[i] = m_err[i]; e.code[i] = m_code[i]; e.cnt[i] = m_cnt[i];
        end
        e.sp = m_sp;
        e.full = (m_sp == D); e.empty = (m_sp == 0); e.thr = (m_sp >= D / 2);
        e.afull = (m_sp >= 3); e.aempty = (m_sp <= 1);
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int p, input int o, input int k, input int c);
        drive(p, o, k, c);
        drive(0, 0, 0, 0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        check_eq("q_drain", exp_q.size(), 0);
    endtask

    // Monitor: strobes mid-cycle, registered state just after the edge.
    initial begin
        int cwe0, cre0, cad0, cwe1, cre1, cad1;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            cwe0 = we0; cre0 = re0; cad0 = addr0;
            cwe1 = we1; cre1 = re1; cad1 = addr1;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("mem_we0", cwe0, e.we);
                check_eq("mem_re0", cre0, e.re);
                check_eq("mem_addr0", cad0, e.addr);
                check_eq("mem_we1", cwe1, e.we);
                check_eq("mem_re1", cre1, e.re);
                check_eq("mem_addr1", cad1, e.addr);
                check_eq("sp0", sp0, e.sp);
                check_eq("sp1", sp1, e.sp);
                check_eq("full", full0, e.full);
                check_eq("empty", empty0, e.empty);
                check_eq("threshold", thr0, e.thr);
                check_eq("afull", afull0, e.afull);
                check_eq("aempty", aempty0, e.aempty);
                check_eq("error0", err0, e.err[0]);
                check_eq("err_code0", code0, e.code[0]);
                check_eq("err_count0", cnt0, e.cnt[0]);
                check_eq("error1", err1, e.err[1]);
                check_eq("err_code1", code1, e.code[1]);
                check_eq("err_count1", cnt1, e.cnt[1]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_sp", sp0, 0);
        check_eq("rst_empty", empty0, 1);
        check_eq("rst_aempty", aempty0, 1);
        check_eq("rst_full", full0, 0);
        check_eq("rst_thr", thr0, 0);
        check_eq("rst_afull", afull0, 0);
        check_eq("rst_error", err0, 0);
        check_eq("rst_cnt", cnt0, 0);
        @(negedge clk);
        rst_edge = 1'b0;

        // Fill, overflow, then pop (auto-clear only on the non-sticky instance)
        for (int i = 0; i < 4; i++) pulse(1, 0, 0, 0);
        drain();
        check_eq("fill_sp", sp0, 4);
        check_eq("fill_full", full0, 1);
        pulse(1, 0, 0, 0);
        drain();
        check_eq("ovf_code", code0, 1);
        check_eq("ovf_cnt", cnt0, 1);
        pulse(0, 1, 0, 0);
        drain();
        check_eq("pop_clr_err0", err0, 0);
        check_eq("pop_sticky_err1", err1, 1);
        pulse(0, 0, 0, 1);

        // Drain to empty, underflow then peek-on-empty: first cause held
        for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        drain();
        check_eq("held_code", code0, 2);
        check_eq("held_cnt", cnt0, 2);
        pulse(0, 0, 0, 1);
        drain();
        check_eq("clr_cnt", cnt0, 0);

        // Simultaneous push+pop: replace top, then on empty
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        drain();
        check_eq("replace_sp", sp0, 2);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 1, 0, 0);
        drain();
        check_eq("pp_empty_sp", sp0, 1);
        check_eq("pp_empty_err", err0, 0);

        // Held request gives one push; peek while pushing is ignored
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drain();
        check_eq("held_push_sp", sp0, 1);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 1, 0);

        // Error coincident with clr_err, then saturate the 2-bit counter
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 1);
        drain();
        check_eq("clr_coinc_cnt", cnt0, 1);
        for (int i = 0; i < 5; i++) pulse(0, 1, 0, 0);
        drain();
        check_eq("sat_cnt1", cnt1, 3);

        // Async reset between edges with sp=3 and error set
        for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
        drain();
        rst_edge = 1'b1;
        #1;
        check_eq("arst_sp", sp1, 0);
        check_eq("arst_error", err1, 0);
        check_eq("arst_empty", empty1, 1);
        model_reset();
        @(negedge clk);
        rst_edge = 1'b0;
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_status_ctrl.md
Name: stack_status_ctrl

Overview:
Parametrised stack controller for the stack subsystem.
- Owns the stack pointer and detects push/pop/peek request edges internally.
- Generates memory access strobes and address, full/empty/half/almost flags, and a classified error status with a saturating error counter.
- Sits between the button/request inputs and the stack RAM, replacing separate pointer and status logic.

Parameters:
STACK_DEPTH, 16, number of stack entries (power of two, >=4)
STICKY_ERR, 0, 1: error cleared only by clr_err; 0: also cleared by next successful operation
ERR_CNT_W, 8, width of error event counter
(localparam PTR_W = $clog2(STACK_DEPTH)+1)

Ports:
clk  input  1  clock, all state on rising edge
rst_edge  input  1  asynchronous reset, active-high
push_req  input  1  push request level; acts on rising edge
pop_req  input  1  pop request level; acts on rising edge
peek_req  input  1  read-top-without-pop request level; acts on rising edge
clr_err  input  1  synchronous clear of error, err_code, err_count
afull_lvl  input  PTR_W  almost-full threshold
aempty_lvl  input  PTR_W  almost-empty threshold
sp  output  PTR_W  registered stack pointer, number of valid entries
mem_we  output  1  write strobe to stack RAM, combinational
mem_re  output  1  read strobe to stack RAM, combinational
mem_addr  output  PTR_W-1  RAM address, combinational
stack_full, stack_empty, stack_threshold, stack_afull, stack_aempty  output  1 each  status flags
error  output  1  registered error flag
err_code  output  2  00 none, 01 overflow, 10 underflow (pop on empty), 11 peek on empty
err_count  output  ERR_CNT_W  saturating count of error events

Behaviour:
- Reset (rst_edge=1, async): sp=0, error=0, err_code=00, err_count=0, request delay regs=0. Flags follow sp=0: empty=1, aempty=1 (for aempty_lvl>=0), all other flags 0.
- Edge detect: e_x = x_req & ~x_req_d; x_req_d registered each cycle. A request held high through reset release produces one edge on the first clock after release.
- Flags (combinational from registered sp):
  - full: sp==STACK_DEPTH
  - empty: sp==0
  - threshold: sp>=STACK_DEPTH/2
  - afull: sp>=afull_lvl
  - aempty: sp<=aempty_lvl
- Operation decode in the detection cycle. Strobes and addr are combinational that cycle; sp, error and counters update at the next clock edge.
  - Push only, not full: mem_we=1, mem_addr=sp, sp<=sp+1.
  - Push only, full: overflow error, no strobe, sp unchanged.
  - Pop only, not empty: mem_re=1, mem_addr=sp-1, sp<=sp-1.
  - Pop only, empty: underflow error.
  - Push+pop, not empty (including full): replace top. mem_re=1 and mem_we=1, mem_addr=sp-1, sp unchanged, no error.
  - Push+pop, empty: push performed, pop dropped, no error.
  - Peek (no push/pop edge), not empty: mem_re=1, mem_addr=sp-1, sp unchanged. Peek on empty: code 11 error.
  - Peek coincident with push or pop: peek ignored.
- No strobe or addr change without an edge. mem_addr=0 when idle.
- sp never wraps: it never exceeds STACK_DEPTH and never goes below 0.
- Error FSM, states OK / ERR:
  - OK -> ERR on any error event. err_code latches the cause.
  - In ERR, further errors do not change err_code (first cause held) but do increment err_count.
  - ERR -> OK on clr_err.
  - If STICKY_ERR=0, ERR -> OK also on the next successful push/pop/peek; err_code<=00 and err_count is kept.
  - clr_err coincident with an error event: result is error=1, err_code=new cause, err_count=1.
- err_count increments by 1 per error event and saturates at 2^ERR_CNT_W-1.
- Reset mid-operation: all state returns to reset values immediately; a pending edge is discarded.

Test Plan:
- STACK_DEPTH=4: reset, 4 push pulses -> sp 1,2,3,4; mem_addr 0,1,2,3 with mem_we; threshold at sp=2; full at 4; afull at sp>=3 with afull_lvl=3.
- At full, push pulse -> error=1, err_code=01, err_count=1, sp=4, no mem_we. Then pop -> mem_addr=3, sp=3; with STICKY_ERR=0 error=0, err_count=1.
- Empty stack, pop pulse then peek pulse -> err_code=10 held (not 11), err_count=2. clr_err -> error=0, code=00, count=0.
- sp=2, push and pop rise in the same cycle -> mem_we=mem_re=1, mem_addr=1, sp stays 2. On empty, same stimulus -> push only, sp=1, error=0.
- push_req held high 10 cycles -> exactly one push. With STICKY_ERR=1, after an overflow a successful pop leaves error=1 until clr_err.
- Assert rst_edge between clock edges with sp=3, error=1 -> sp=0, error=0, empty=1 immediately. ERR_CNT_W=2 with 5 errors -> err_count=3.
